memctrl_seq: RTL

MEMCTRL_SEQ -- requirements
Module: memctrl_seq

---
 rtl/memctrl_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/memctrl_seq.sv
// memctrl_seq: byte-serial RAM sequencer shared by an instruction-fetch port and a load/store port.
// Define MEMCTRL_RR_ARB_EN to alternate grants on simultaneous requests (default: load/store wins).
module memctrl_seq #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_req,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          if_done,
  output logic [8*WORD_BYTES-1:0]       if_data,
  input  logic                          mem_req,
  input  logic                          mem_wr,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [$clog2(WORD_BYTES)-1:0] mem_len,
  input  logic [8*WORD_BYTES-1:0]       mem_wdata,
  output logic                          mem_done,
  output logic [8*WORD_BYTES-1:0]       mem_rdata,
  input  logic [7:0]                    ram_din,
  output logic                          ram_wr,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [7:0]                    ram_dout
);

  localparam int LW = $clog2(WORD_BYTES);
  localparam int DW = 8 * WORD_BYTES;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     cnt;
  logic [LW-1:0]     cnt_inc;
  logic              wr_q;
  logic              gnt_mem;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rbuf;
  logic [DW-1:0]     rbuf_nxt;
  logic [7:0]        wbyte;
  logic [ADDR_W-1:0] beat_addr;
  logic              start;
  logic              pick_mem;

  assign start     = (state == S_IDLE) && (if_req || mem_req);
  assign cnt_inc   = cnt + 1'b1;
  assign beat_addr = base_q + ADDR_W'(cnt);

`ifdef MEMCTRL_RR_ARB_EN
  logic last_mem;

  // A tie goes to whichever port was not granted at the previous start.
  assign pick_mem = mem_req & ~(if_req & last_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_mem <= 1'b0;
    end else if (start) begin
      last_mem <= pick_mem;
    end
  end
`else
  assign pick_mem = mem_req;
`endif

  always_comb begin
    rbuf_nxt = rbuf;
    wbyte    = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (cnt == LW'(b)) begin
        rbuf_nxt[8*b +: 8] = ram_din;
        wbyte              = wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      gnt_mem   <= 1'b0;
      wdata_q   <= '0;
      rbuf      <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            gnt_mem <= pick_mem;
            base_q  <= pick_mem ? mem_addr : if_addr;
            len_q   <= pick_mem ? mem_len : '1;
            wr_q    <= pick_mem & mem_wr;
            wdata_q <= mem_wdata;
            cnt     <= '0;
            rbuf    <= '0;
            if (!(pick_mem && mem_wr)) begin
              state <= S_READ;
            end else if (mem_len == '0) begin
              state <= S_DONE;
            end else begin
              state <= S_WRITE;
            end
          end
        end
        S_READ: begin
          rbuf <= rbuf_nxt;
          cnt  <= cnt_inc;
          if (cnt == len_q) begin
            state <= S_DONE;
            if (gnt_mem) begin
              mem_rdata <= rbuf_nxt;
            end else begin
              if_data <= rbuf_nxt;
            end
          end
        end
        S_WRITE: begin
          // The final write beat is driven from DONE, alongside the done pulse.
          cnt <= cnt_inc;
          if (cnt_inc == len_q) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_done  = (state == S_DONE) && !gnt_mem;
  assign mem_done = (state == S_DONE) && gnt_mem;

  always_comb begin
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_dout = '0;
    if (state == S_READ) begin
      ram_addr = beat_addr;
    end
    if (state == S_WRITE || (state == S_DONE && wr_q)) begin
      ram_wr   = 1'b1;
      ram_addr = beat_addr;
      ram_dout = wbyte;
    end
  end

endmodule
